bus_xfer_arbiter: RTL and testbench

- Schedules register-to-register transfers on the shared 4-bit tristate data bus of the register file.
- Up to NREQ requesters (microcode sequencer, ALU writeback, immediate loader) each post a {source, destination} pair.
- Block arbitrates round-robin and drives the one-hot bus-write enables (ws*) and register-load strobes (rs*) of the register slices.
- Guarantees at most one bus driver per cycle and a driver-free cycle between transfers.

---
 rtl/bus_xfer_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_bus_xfer_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_arbiter.sv
// Round-robin scheduler for register-to-register transfers on the shared register-file bus.
// Optional macro XFER_ID_CHECK_EN adds an err port and rejects bad or self-targeted id pairs.
module bus_xfer_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned NSRC = 6,
  parameter int unsigned NDST = 6,
  parameter int unsigned IDW  = 3
) (
  input  logic                 clk,
  input  logic                 grst_n,
  input  logic                 lrst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*IDW-1:0]  src_id,
  input  logic [NREQ*IDW-1:0]  dst_id,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [NSRC-1:0]      ws,
  output logic [NDST-1:0]      rs,
`ifdef XFER_ID_CHECK_EN
  output logic                 err,
`endif
  output logic                 busy
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
`ifdef XFER_ID_CHECK_EN
    REJECT = 2'd3,
`endif
    LOAD   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_d;
  logic [IDW-1:0]    src_q, src_d;
  logic [IDW-1:0]    dst_q, dst_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [NSRC-1:0]   ws_q, ws_d;
  logic [NDST-1:0]   rs_q, rs_d;
  logic              busy_q, busy_d;
`ifdef XFER_ID_CHECK_EN
  logic              err_q, err_d;
  logic              id_bad;
`endif

  logic [IDW-1:0]    src_a [NREQ];
  logic [IDW-1:0]    dst_a [NREQ];
  logic [PW-1:0]     pick;
  logic [PW-1:0]     ptr_inc;
  logic [NSRC-1:0]   src_dec;
  logic [NDST-1:0]   dst_dec;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign src_a[g] = src_id[g*IDW +: IDW];
    assign dst_a[g] = dst_id[g*IDW +: IDW];
  end

  // First requester at or above the pointer, wrapping past NREQ-1.
  function automatic logic [PW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
    logic [PW-1:0] w;
    logic          hit;
    int            idx;
    w   = '0;
    hit = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(p) + k;
      if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
      if (!hit && r[PW'(idx)]) begin
        hit = 1'b1;
        w   = PW'(idx);
      end
    end
    return w;
  endfunction

  assign pick    = rr_pick(req, ptr_q);
  assign ptr_inc = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);

`ifdef XFER_ID_CHECK_EN
  assign id_bad = (32'(src_a[pick]) >= NSRC) || (32'(dst_a[pick]) >= NDST) ||
                  (src_a[pick] == dst_a[pick]);
`endif

  // Id decode; out-of-range ids light no strobe.
  always_comb begin
    src_dec = '0;
    dst_dec = '0;
    for (int j = 0; j < NSRC; j++) src_dec[j] = (src_d == IDW'(j));
    for (int j = 0; j < NDST; j++) dst_dec[j] = (dst_d == IDW'(j));
  end

  // State, pointer and captured-transfer registers plus registered outputs.
  always_ff @(posedge clk or negedge grst_n) begin
    if (!grst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      ws_q    <= '0;
      rs_q    <= '0;
      busy_q  <= 1'b0;
`ifdef XFER_ID_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      ws_q    <= ws_d;
      rs_q    <= rs_d;
      busy_q  <= busy_d;
`ifdef XFER_ID_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next state; ids are captured only at grant.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    src_d   = src_q;
    dst_d   = dst_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          win_d   = pick;
          src_d   = src_a[pick];
          dst_d   = dst_a[pick];
          state_d = DRIVE;
`ifdef XFER_ID_CHECK_EN
          if (id_bad) state_d = REJECT;
`endif
        end
      end
      DRIVE: state_d = LOAD;
      LOAD: begin
        state_d = IDLE;
        ptr_d   = ptr_inc;
      end
`ifdef XFER_ID_CHECK_EN
      REJECT: begin
        state_d = IDLE;
        ptr_d   = ptr_inc;
      end
`endif
      default: state_d = IDLE;
    endcase
    if (lrst) begin
      state_d = IDLE;
      ptr_d   = '0;
    end
  end

  // Output values for the state being entered, registered above.
  always_comb begin
    gnt_d  = '0;
    done_d = '0;
    ws_d   = '0;
    rs_d   = '0;
    busy_d = (state_d != IDLE);
`ifdef XFER_ID_CHECK_EN
    err_d  = 1'b0;
`endif
    case (state_d)
      DRIVE: begin
        gnt_d[win_d] = 1'b1;
        ws_d         = src_dec;
      end
      LOAD: begin
        gnt_d[win_d]  = 1'b1;
        done_d[win_d] = 1'b1;
        ws_d          = src_dec;
        rs_d          = dst_dec;
      end
`ifdef XFER_ID_CHECK_EN
      REJECT: begin
        gnt_d[win_d]  = 1'b1;
        done_d[win_d] = 1'b1;
        err_d         = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign ws   = ws_q;
  assign rs   = rs_q;
  assign busy = busy_q;
`ifdef XFER_ID_CHECK_EN
  assign err  = err_q;
`endif

endmodule

// File: tb/tb_bus_xfer_arbiter.sv
// Directed vector bench for bus_xfer_arbiter (default build, 3 requesters, 6 sources/destinations).
module tb_bus_xfer_arbiter;

  logic       clk = 1'b0;
  logic       grst_n;
  logic       lrst;
  logic [2:0] req;
  logic [8:0] src_id;
  logic [8:0] dst_id;
  logic [2:0] gnt;
  logic [2:0] done;
  logic [5:0] ws;
  logic [5:0] rs;
  logic       busy;

  int errors = 0;
  int checks = 0;

  bus_xfer_arbiter #(.NREQ(3), .NSRC(6), .NDST(6), .IDW(3)) dut (
    .clk    (clk),
    .grst_n (grst_n),
    .lrst   (lrst),
    .req    (req),
    .src_id (src_id),
    .dst_id (dst_id),
    .gnt    (gnt),
    .done   (done),
    .ws     (ws),
    .rs     (rs),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       lrst;
    logic [2:0] req;
    logic [8:0] src;
    logic [8:0] dst;
    logic [2:0] gnt;
    logic [2:0] done;
    logic [5:0] ws;
    logic [5:0] rs;
    logic       busy;
  } vec_t;

  vec_t vq[$];

  function automatic logic [8:0] ids(input logic [2:0] i0, input logic [2:0] i1, input logic [2:0] i2);
    return {i2, i1, i0};
  endfunction

  task automatic add(input logic l, input logic [2:0] r, input logic [8:0] s, input logic [8:0] d,
                     input logic [2:0] g, input logic [2:0] dn, input logic [5:0] w,
                     input logic [5:0] rr, input logic b);
    vec_t v;
    v.lrst = l; v.req = r; v.src = s; v.dst = d;
    v.gnt = g; v.done = dn; v.ws = w; v.rs = rr; v.busy = b;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] g, input logic [2:0] dn,
                         input logic [5:0] w, input logic [5:0] rr, input logic b);
    chk({tag, ".gnt"},  32'(gnt),  32'(g));
    chk({tag, ".done"}, 32'(done), 32'(dn));
    chk({tag, ".ws"},   32'(ws),   32'(w));
    chk({tag, ".rs"},   32'(rs),   32'(rr));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  initial begin
    logic [8:0] s_rr;
    logic [8:0] d_rr;
    s_rr = ids(3'd1, 3'd2, 3'd5);
    d_rr = ids(3'd4, 3'd3, 3'd0);
    // Single transfer: req[1], src 3 -> dst 0; req dropped during LOAD.
    add(0, 3'b010, ids(3'd0, 3'd3, 3'd0), ids(3'd0, 3'd0, 3'd0), 3'b010, 3'b000, 6'b001000, 6'b000000, 1);
    add(0, 3'b000, ids(3'd0, 3'd3, 3'd0), ids(3'd0, 3'd0, 3'd0), 3'b010, 3'b010, 6'b001000, 6'b000001, 1);
    add(0, 3'b000, 9'd0, 9'd0, 3'b000, 3'b000, 6'b000000, 6'b000000, 0);
    // Clear pointer, then round-robin with all requests held.
    add(1, 3'b000, 9'd0, 9'd0, 3'b000, 3'b000, 6'b000000, 6'b000000, 0);
    add(0, 3'b111, s_rr, d_rr, 3'b001, 3'b000, 6'b000010, 6'b000000, 1);
    add(0, 3'b111, s_rr, d_rr, 3'b001, 3'b001, 6'b000010, 6'b010000, 1);
    add(0, 3'b111, s_rr, d_rr, 3'b000, 3'b000, 6'b000000, 6'b000000, 0);
    add(0, 3'b111, s_rr, d_rr, 3'b010, 3'b000, 6'b000100, 6'b000000, 1);
    add(0, 3'b111, s_rr, d_rr, 3'b010, 3'b010, 6'b000100, 6'b001000, 1);
    add(0, 3'b111, s_rr, d_rr, 3'b000, 3'b000, 6'b000000, 6'b000000, 0);
    add(0, 3'b111, s_rr, d_rr, 3'b100, 3'b000, 6'b100000, 6'b000000, 1);
    add(0, 3'b111, s_rr, d_rr, 3'b100, 3'b100, 6'b100000, 6'b000001, 1);
    add(0, 3'b111, s_rr, d_rr, 3'b000, 3'b000, 6'b000000, 6'b000000, 0);
    add(0, 3'b111, s_rr, d_rr, 3'b001, 3'b000, 6'b000010, 6'b000000, 1);
    add(0, 3'b000, s_rr, d_rr, 3'b001, 3'b001, 6'b000010, 6'b010000, 1);
    add(0, 3'b000, s_rr, d_rr, 3'b000, 3'b000, 6'b000000, 6'b000000, 0);
    // Id capture: src_id[0] changes 2 -> 5 after grant; pointer 1 wraps to requester 0.
    add(0, 3'b001, ids(3'd2, 3'd0, 3'd0), ids(3'd1, 3'd0, 3'd0), 3'b001, 3'b000, 6'b000100, 6'b000000, 1);
    add(0, 3'b000, ids(3'd5, 3'd0, 3'd0), ids(3'd1, 3'd0, 3'd0), 3'b001, 3'b001, 6'b000100, 6'b000010, 1);
    add(0, 3'b000, 9'd0, 9'd0, 3'b000, 3'b000, 6'b000000, 6'b000000, 0);
    // lrst at end of DRIVE: transfer abandoned, no LOAD, no done.
    add(0, 3'b010, ids(3'd0, 3'd0, 3'd0), ids(3'd0, 3'd5, 3'd0), 3'b010, 3'b000, 6'b000001, 6'b000000, 1);
    add(1, 3'b000, 9'd0, 9'd0, 3'b000, 3'b000, 6'b000000, 6'b000000, 0);
    // Pointer now 0: req 101 grants 0.
    add(0, 3'b101, ids(3'd3, 3'd0, 3'd4), ids(3'd2, 3'd0, 3'd4), 3'b001, 3'b000, 6'b001000, 6'b000000, 1);
    add(0, 3'b000, ids(3'd3, 3'd0, 3'd4), ids(3'd2, 3'd0, 3'd4), 3'b001, 3'b001, 6'b001000, 6'b000100, 1);
    // lrst at end of LOAD: pointer back to 0 instead of 1.
    add(1, 3'b000, 9'd0, 9'd0, 3'b000, 3'b000, 6'b000000, 6'b000000, 0);
    add(0, 3'b011, ids(3'd3, 3'd0, 3'd0), ids(3'd2, 3'd5, 3'd0), 3'b001, 3'b000, 6'b001000, 6'b000000, 1);
    add(0, 3'b000, ids(3'd3, 3'd0, 3'd0), ids(3'd2, 3'd5, 3'd0), 3'b001, 3'b001, 6'b001000, 6'b000100, 1);
    add(0, 3'b000, 9'd0, 9'd0, 3'b000, 3'b000, 6'b000000, 6'b000000, 0);
    // req[2] with src == dst == 4 completes normally.
    add(0, 3'b100, ids(3'd0, 3'd0, 3'd4), ids(3'd0, 3'd0, 3'd4), 3'b100, 3'b000, 6'b010000, 6'b000000, 1);
    add(0, 3'b000, ids(3'd0, 3'd0, 3'd4), ids(3'd0, 3'd0, 3'd4), 3'b100, 3'b100, 6'b010000, 6'b010000, 1);
    add(0, 3'b000, 9'd0, 9'd0, 3'b000, 3'b000, 6'b000000, 6'b000000, 0);
    // Out-of-range ids: no strobes but done still pulses.
    add(0, 3'b010, ids(3'd0, 3'd7, 3'd0), ids(3'd0, 3'd6, 3'd0), 3'b010, 3'b000, 6'b000000, 6'b000000, 1);
    add(0, 3'b000, ids(3'd0, 3'd7, 3'd0), ids(3'd0, 3'd6, 3'd0), 3'b010, 3'b010, 6'b000000, 6'b000000, 1);
    add(0, 3'b000, 9'd0, 9'd0, 3'b000, 3'b000, 6'b000000, 6'b000000, 0);

    grst_n = 1'b0;
    lrst   = 1'b0;
    req    = '0;
    src_id = '0;
    dst_id = '0;
    repeat (2) @(negedge clk);
    chk_all("reset", 3'b000, 3'b000, 6'b000000, 6'b000000, 1'b0);
    grst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      lrst   = vq[i].lrst;
      req    = vq[i].req;
      src_id = vq[i].src;
      dst_id = vq[i].dst;
      @(posedge clk);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vq[i].gnt, vq[i].done, vq[i].ws, vq[i].rs, vq[i].busy);
    end

    // Async reset mid-DRIVE; pointer is 2 so req[0] wins.
    lrst   = 1'b0;
    req    = 3'b001;
    src_id = ids(3'd2, 3'd0, 3'd0);
    dst_id = ids(3'd3, 3'd0, 3'd0);
    @(posedge clk);
    @(negedge clk);
    chk_all("pre_areset", 3'b001, 3'b000, 6'b000100, 6'b000000, 1'b1);
    #2 grst_n = 1'b0;
    #1 chk_all("areset", 3'b000, 3'b000, 6'b000000, 6'b000000, 1'b0);
    req = 3'b000;
    @(negedge clk);
    grst_n = 1'b1;
    // Pointer 0 after reset: req 101 grants 0, not 2.
    req    = 3'b101;
    src_id = ids(3'd1, 3'd0, 3'd3);
    dst_id = ids(3'd2, 3'd0, 3'd3);
    @(posedge clk);
    @(negedge clk);
    chk_all("post_areset", 3'b001, 3'b000, 6'b000010, 6'b000000, 1'b1);
    req = 3'b000;
    @(posedge clk);
    @(negedge clk);
    chk_all("post_areset_load", 3'b001, 3'b001, 6'b000010, 6'b000100, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
